// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, per-register latency scoreboard,
// merged global stalls, mispredict/exception flushes and a saturating stall counter.
module hazard_ctrl #(
  parameter int NREG  = 32,
  parameter int AW    = 5,
  parameter int LAT_W = 3
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [AW-1:0]    rsD,
  input  logic [AW-1:0]    rtD,
  input  logic             rs_usedD,
  input  logic             rt_usedD,
  input  logic             regwriteD,
  input  logic [AW-1:0]    writeregD,
  input  logic [LAT_W-1:0] latD,
  input  logic [AW-1:0]    rsE,
  input  logic [AW-1:0]    rtE,
  input  logic [AW-1:0]    writeregM,
  input  logic             regwrite_enM,
  input  logic [AW-1:0]    writeregW,
  input  logic             regwrite_enW,
  input  logic             i_stall,
  input  logic             d_stall,
  input  logic             stall_divE,
  input  logic             br_mispredE,
  input  logic             exc_req,
  output logic             forwardaD,
  output logic             forwardbD,
  output logic [1:0]       forwardaE,
  output logic [1:0]       forwardbE,
  output logic             longest_stall,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             stallM,
  output logic             stallW,
  output logic             flushF,
  output logic             flushD,
  output logic             flushE,
  output logic             flushM,
  output logic             flushW,
  output logic [31:0]      stall_cycles
);

  logic [LAT_W-1:0] w_cnt [NREG];
  logic             r_exc_pend;
  logic [31:0]      r_stall_cycles;
  logic             w_longest, w_flush_all, w_rs_busy, w_rt_busy;
  logic             w_sb_stall, w_issue, w_stallD;

  function automatic logic [1:0] fwd_e(input logic [AW-1:0] src,
                                       input logic [AW-1:0] wrM, input logic enM,
                                       input logic [AW-1:0] wrW, input logic enW);
    if (src != '0 && src == wrM && enM)      return 2'b10;
    else if (src != '0 && src == wrW && enW) return 2'b01;
    else                                     return 2'b00;
  endfunction

  always_comb begin
    w_longest   = i_stall | d_stall | stall_divE;
    w_flush_all = (exc_req | r_exc_pend) & ~w_longest;
    w_rs_busy   = rs_usedD && (rsD != '0) && (w_cnt[rsD] != '0);
    w_rt_busy   = rt_usedD && (rtD != '0) && (w_cnt[rtD] != '0);
    w_sb_stall  = (w_rs_busy | w_rt_busy) & ~br_mispredE & ~w_flush_all & ~w_longest;
    w_issue     = ~w_longest & ~w_sb_stall & ~br_mispredE & ~w_flush_all &
                  regwriteD & (writeregD != '0) & (latD != '0);
    w_stallD    = w_longest | w_sb_stall;
  end

  always_comb begin
    forwardaD     = (rsD != '0) && (rsD == writeregM) && regwrite_enM;
    forwardbD     = (rtD != '0) && (rtD == writeregM) && regwrite_enM;
    forwardaE     = fwd_e(rsE, writeregM, regwrite_enM, writeregW, regwrite_enW);
    forwardbE     = fwd_e(rtE, writeregM, regwrite_enM, writeregW, regwrite_enW);
    longest_stall = w_longest;
    stallF        = w_stallD;
    stallD        = w_stallD;
    stallE        = w_longest;
    stallM        = w_longest;
    stallW        = w_longest;
    flushF        = w_flush_all;
    flushD        = (br_mispredE | w_flush_all) & ~w_longest;
    flushE        = w_sb_stall | w_flush_all;
    flushM        = w_flush_all;
    flushW        = w_flush_all;
    stall_cycles  = r_stall_cycles;
  end

  // Scoreboard: a fresh issue overrides the countdown; counters freeze under global stall.
  for (genvar g = 0; g < NREG; g++) begin : g_sb
    logic [LAT_W-1:0] r_cnt;
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)                                 r_cnt <= '0;
      else if (w_flush_all)                        r_cnt <= '0;
      else if (w_issue && writeregD == AW'(g))     r_cnt <= latD;
      else if (!w_longest && r_cnt != '0)          r_cnt <= r_cnt - LAT_W'(1);
    end
    assign w_cnt[g] = r_cnt;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                      r_exc_pend <= 1'b0;
    else if (w_flush_all)             r_exc_pend <= 1'b0;
    else if (exc_req && w_longest)    r_exc_pend <= 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                                  r_stall_cycles <= '0;
    else if (w_stallD && r_stall_cycles != '1)    r_stall_cycles <= r_stall_cycles + 32'd1;
  end

endmodule
